// File: rtl/uart_transceiver.sv
// UART transceiver with independent TX and RX paths. Frame: start, DATA_W bits LSB first, STOP_BITS stops.
// Define UART_PARITY_EN to insert an even-parity bit on TX and check it on RX.
module uart_transceiver #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    tx_state_e         tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_clk_q, tx_clk_d;
    logic [BW-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              txd_q, txd_d;
    logic              tx_clk_end;
`ifdef UART_PARITY_EN
    logic              tx_par_q, tx_par_d;
`endif

    rx_state_e         rx_state_q, rx_state_d;
    logic [2:0]        rx_sync_q, rx_sync_d;
    logic [CW-1:0]     rx_clk_q, rx_clk_d;
    logic [BW-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_frame_err_q, rx_frame_err_d;
    logic              rx_bit_in;
    logic              rx_clk_end;
`ifdef UART_PARITY_EN
    logic              rx_par_bad_q, rx_par_bad_d;
    logic              rx_parity_err_q, rx_parity_err_d;
`endif

    // txd is registered from the next state so the line never glitches.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_clk_d   = tx_clk_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        tx_clk_end = (tx_clk_q == CLK_LAST);
        if (tx_state_q != TX_IDLE) begin
            tx_clk_d = tx_clk_end ? '0 : tx_clk_q + 1'b1;
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
`ifdef UART_PARITY_EN
                    tx_par_d   = ^tx_data;
`endif
                end
            end
            TX_START: begin
                if (tx_clk_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_clk_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_bit_d = '0;
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
`else
                        tx_state_d = TX_STOP;
`endif
                    end
                end
            end
            TX_PARITY: begin
                if (tx_clk_end) begin
                    tx_state_d = TX_STOP;
                    tx_bit_d   = '0;
                end
            end
            TX_STOP: begin
                if (tx_clk_end) begin
                    if (tx_bit_q == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        txd_d = 1'b1;
        case (tx_state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            TX_PARITY: txd_d = tx_par_d;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_clk_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_clk_q   <= tx_clk_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // rx_sync_q[1] is the synchronised line; rx_sync_q[2] is its previous value for edge detection.
    always_comb begin
        rx_sync_d      = {rx_sync_q[1:0], rxd};
        rx_state_d     = rx_state_q;
        rx_clk_d       = rx_clk_q;
        rx_bit_d       = rx_bit_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_bad_d    = rx_par_bad_q;
        rx_parity_err_d = 1'b0;
`endif
        rx_bit_in  = rx_sync_q[1];
        rx_clk_end = (rx_state_q == RX_START) ? (rx_clk_q == CLK_HALF) : (rx_clk_q == CLK_LAST);
        if (rx_state_q != RX_IDLE && rx_state_q != RX_WAIT_HIGH) begin
            rx_clk_d = rx_clk_end ? '0 : rx_clk_q + 1'b1;
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_sync_q[2] && !rx_bit_in) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_clk_end) begin
                    rx_bit_d = '0;
`ifdef UART_PARITY_EN
                    rx_par_bad_d = 1'b0;
`endif
                    rx_state_d = rx_bit_in ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_clk_end) begin
                    rx_shift_d = {rx_bit_in, rx_shift_q[DATA_W-1:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == BIT_LAST) begin
                        rx_bit_d = '0;
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end
                end
            end
            RX_PARITY: begin
                if (rx_clk_end) begin
`ifdef UART_PARITY_EN
                    rx_par_bad_d = rx_bit_in ^ (^rx_shift_q);
`endif
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // Only the first stop bit is checked; a second one simply reads as idle line.
                if (rx_clk_end) begin
                    if (rx_bit_in) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
`ifdef UART_PARITY_EN
                        rx_parity_err_d = rx_par_bad_q;
`endif
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_frame_err_d = 1'b1;
                        rx_state_d     = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_bit_in) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q     <= RX_IDLE;
            rx_sync_q      <= 3'b111;
            rx_clk_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad_q    <= 1'b0;
            rx_parity_err_q <= 1'b0;
`endif
        end else begin
            rx_state_q     <= rx_state_d;
            rx_sync_q      <= rx_sync_d;
            rx_clk_q       <= rx_clk_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
`ifdef UART_PARITY_EN
            rx_par_bad_q    <= rx_par_bad_d;
            rx_parity_err_q <= rx_parity_err_d;
`endif
        end
    end

    assign tx_ready     = (tx_state_q == TX_IDLE);
    assign txd          = txd_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_parity_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: loopback and directly driven frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_transceiver;
    localparam int DW   = 8;
    localparam int CPB  = 4;
    localparam int STOP = 1;
`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_CYC = (1 + DW + PAR_BITS + STOP) * CPB;
    localparam int LAT_MAX   = FRAME_CYC + 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          txd;
    logic          rxd;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_err;
    logic          rx_parity_err;
    logic          loop_en;
    logic          rxd_drv;

    assign rxd = loop_en ? txd : rxd_drv;

    uart_transceiver #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (STOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .txd          (txd),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- RX event recorder ----------------
    logic [DW-1:0] got_q[$];
    int            got_cyc_q[$];
    int            ferr_cnt = 0;
    int            perr_cnt = 0;
    int            perr_valid_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) begin
            got_q.push_back(rx_data);
            got_cyc_q.push_back(cyc);
        end
        if (rx_frame_err === 1'b1) ferr_cnt++;
        if (rx_parity_err === 1'b1) perr_cnt++;
        if (rx_parity_err === 1'b1 && rx_valid === 1'b1) perr_valid_cnt++;
    end

    // ---------------- scoreboard / model ----------------
    logic [DW-1:0] exp_q[$];
    logic          frame_bits[$];
    int            n_assert = 0;
    int            n_fail = 0;
    int            got_rd = 0;
    int            hs_cyc = 0;
    int            last_rx_cyc = 0;
    logic [DW-1:0] last_good = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Line levels of one frame, one entry per bit period.
    task automatic make_frame(input logic [DW-1:0] w, input bit bad_par, input bit bad_stop);
        frame_bits.delete();
        frame_bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) frame_bits.push_back(w[i]);
        for (int i = 0; i < PAR_BITS; i++) frame_bits.push_back((^w) ^ bad_par);
        for (int i = 0; i < STOP; i++) frame_bits.push_back(!(bad_stop && i == 0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic handshake(input logic [DW-1:0] w, input bit hold);
        int waited = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("tx_ready_wait", 32'(tx_ready), 1);
        @(posedge clk);
        @(negedge clk);
        hs_cyc = cyc;
        exp_q.push_back(w);
        if (!hold) begin
            tx_valid = 1'b0;
            tx_data  = DW'($urandom);
        end
    endtask

    task automatic check_tx_frame(input logic [DW-1:0] w, input bit scramble);
        make_frame(w, 1'b0, 1'b0);
        for (int c = 0; c < FRAME_CYC; c++) begin
            check("txd_bit", 32'(txd), 32'(frame_bits[c / CPB]));
            check("tx_ready_busy", 32'(tx_ready), 0);
            if (scramble) begin
                tx_data  = DW'($urandom);
                tx_valid = (c < FRAME_CYC - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
        end
        check("tx_ready_rise", 32'(tx_ready), 1);
    endtask

    task automatic drive_frame(input logic [DW-1:0] w, input bit bad_par, input bit bad_stop);
        make_frame(w, bad_par, bad_stop);
        for (int b = 0; b < frame_bits.size(); b++) begin
            rxd_drv = frame_bits[b];
            repeat (CPB) @(negedge clk);
        end
        rxd_drv = 1'b1;
    endtask

    task automatic wait_rx(input int budget);
        int            waited = 0;
        logic [DW-1:0] want;
        while (got_q.size() <= got_rd && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check("rx_arrived", 32'(got_q.size() > got_rd), 1);
        if (got_q.size() > got_rd && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("rx_data", 32'(got_q[got_rd]), 32'(want));
            last_rx_cyc = got_cyc_q[got_rd];
            last_good   = want;
            got_rd++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] w;
        int            ferr_base;
        int            perr_base;
        int            pv_base;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        loop_en  = 1'b1;
        rxd_drv  = 1'b1;
        idle(3);
        check("rst_txd", 32'(txd), 1);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_frame_err", 32'(rx_frame_err), 0);
        check("rst_rx_parity_err", 32'(rx_parity_err), 0);
        rst = 1'b0;
        idle(5);

        // Single word, latency and single-pulse check.
        ferr_base = ferr_cnt;
        handshake(8'hA5, 1'b0);
        check_tx_frame(8'hA5, 1'b1);
        wait_rx(100);
        check("rx_latency_ok", 32'((last_rx_cyc - hs_cyc) <= LAT_MAX), 1);
        idle(10);
        check("a5_single_pulse", 32'(got_q.size()), 32'(got_rd));
        check("a5_no_frame_err", 32'(ferr_cnt - ferr_base), 0);

        // Random words through the loopback.
        for (int i = 0; i < 6; i++) begin
            w = DW'($urandom_range(0, 255));
            idle($urandom_range(0, 6));
            handshake(w, 1'b0);
            check_tx_frame(w, 1'b1);
            wait_rx(100);
        end

        // Back-to-back with tx_valid held high.
        idle(3);
        handshake(8'h3C, 1'b1);
        tx_data = 8'hC3;
        check_tx_frame(8'h3C, 1'b0);
        @(negedge clk);
        hs_cyc = cyc;
        exp_q.push_back(8'hC3);
        tx_valid = 1'b0;
        tx_data  = DW'($urandom);
        check_tx_frame(8'hC3, 1'b0);
        wait_rx(100);
        wait_rx(100);

        // One-cycle glitch on the line must be rejected silently.
        loop_en = 1'b0;
        idle(10);
        ferr_base = ferr_cnt;
        perr_base = perr_cnt;
        rxd_drv = 1'b0;
        @(negedge clk);
        rxd_drv = 1'b1;
        idle(30);
        check("glitch_no_valid", 32'(got_q.size()), 32'(got_rd));
        check("glitch_no_frame_err", 32'(ferr_cnt - ferr_base), 0);
        check("glitch_no_parity_err", 32'(perr_cnt - perr_base), 0);
        w = DW'($urandom_range(0, 255));
        exp_q.push_back(w);
        drive_frame(w, 1'b0, 1'b0);
        wait_rx(60);

        // Bad stop bit, then recovery with a good frame.
        idle(8);
        ferr_base = ferr_cnt;
        drive_frame(8'h55, 1'b0, 1'b1);
        idle(20);
        check("ferr_pulse", 32'(ferr_cnt - ferr_base), 1);
        check("ferr_no_valid", 32'(got_q.size()), 32'(got_rd));
        check("ferr_rx_data_kept", 32'(rx_data), 32'(last_good));
        idle(5);
        w = DW'($urandom_range(0, 255));
        exp_q.push_back(w);
        drive_frame(w, 1'b0, 1'b0);
        wait_rx(60);

        // Reset during data bit 3 of a transmission.
        loop_en = 1'b1;
        idle(5);
        w = DW'($urandom_range(0, 255)) & ~DW'(8);
        handshake(w, 1'b0);
        idle((1 + 3) * CPB + 1);
        check("txd_bit3_before_rst", 32'(txd), 32'(w[3]));
        rst = 1'b1;
        @(negedge clk);
        check("midframe_rst_txd", 32'(txd), 1);
        check("midframe_rst_tx_ready", 32'(tx_ready), 1);
        check("midframe_rst_rx_data", 32'(rx_data), 0);
        rst = 1'b0;
        exp_q.delete();
        last_good = '0;
        idle(10);
        check("midframe_rst_no_rx", 32'(got_q.size()), 32'(got_rd));
        handshake(8'h81, 1'b0);
        check_tx_frame(8'h81, 1'b1);
        wait_rx(100);

`ifdef UART_PARITY_EN
        // Parity bit forced wrong: error flagged alongside valid, data still delivered.
        loop_en = 1'b0;
        idle(5);
        perr_base = perr_cnt;
        pv_base   = perr_valid_cnt;
        exp_q.push_back(8'h07);
        drive_frame(8'h07, 1'b1, 1'b0);
        wait_rx(60);
        idle(5);
        check("par_err_with_valid", 32'(perr_valid_cnt - pv_base), 1);
        check("par_err_pulses", 32'(perr_cnt - perr_base), 1);
`else
        pv_base = perr_valid_cnt;
        check("no_par_err_with_valid", 32'(pv_base), 0);
`endif

        idle(10);
        check("parity_err_total", 32'(perr_cnt), 32'(PAR_BITS));
        check("no_stray_rx", 32'(got_q.size()), 32'(got_rd));
        check("exp_q_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
